// File: rtl/seq_divider_32_pkg.sv
// seq_divider_32_pkg
// Shared definitions for the iterative divider and its subtractor datapath:
//   - state_t        : divider FSM states
//   - DEF_WIDTH      : default operand/result width
//   - cnt_bits()     : iteration counter width for a given operand width
//   - CNT_W          : counter width for the default width
//   - DBZ_QUOTIENT   : quotient reported on divide-by-zero (all ones)
//   - slice_carry()  : carry into bit k of a 4-bit lookahead slice
//   - slice_ggen()   : group generate of a 4-bit lookahead slice
package seq_divider_32_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 32;

  function automatic int cnt_bits(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_bits(DEF_WIDTH);

  localparam logic [DEF_WIDTH-1:0] DBZ_QUOTIENT = '1;

  // Lookahead carry into bit k (0..3) of a slice, flattened from the slice
  // carry-in so no carry ripples bit-to-bit inside the slice.
  function automatic logic slice_carry(input logic [3:0] g, input logic [3:0] p,
                                       input logic cin, input int k);
    logic c;
    case (k)
      0:       c = cin;
      1:       c = g[0] | (p[0] & cin);
      2:       c = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      default: c = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & cin);
    endcase
    return c;
  endfunction

  function automatic logic slice_ggen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/seq_divider_32_cla_subtractor.sv
// cla_subtractor
// Combinational A - B computed as A + ~B + 1 using 4-bit carry-lookahead
// slices; slices are chained by rippling the group carry.
// Both operands are zero-extended to the next multiple of 4 before the
// inversion, so the carry-out of the top slice is a clean no-borrow flag
// (1 when A >= B).
// Parameters:
//   W  : operand width
//   DW : number of low difference bits brought out (DW <= W)
// Ports:
//   i_a, i_b     : operands (W bits)
//   o_diff       : low DW bits of A - B
//   o_no_borrow  : 1 when A >= B
module cla_subtractor
  import seq_divider_32_pkg::*;
#(
  parameter int W  = 33,
  parameter int DW = W
) (
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  output logic [DW-1:0] o_diff,
  output logic          o_no_borrow
);

  localparam int PW = ((W + 3) / 4) * 4;
  localparam int NS = PW / 4;

  logic [PW-1:0] w_a;
  logic [PW-1:0] w_bn;
  logic [PW-1:0] w_g;
  logic [PW-1:0] w_p;
  logic [NS:0]   w_c;

  assign w_a    = PW'(i_a);
  assign w_bn   = ~(PW'(i_b));
  assign w_g    = w_a & w_bn;
  assign w_p    = w_a ^ w_bn;
  // The +1 of the two's complement enters as the carry into slice 0.
  assign w_c[0] = 1'b1;

  for (genvar s = 0; s < NS; s++) begin : g_slice
    logic [3:0] w_gs;
    logic [3:0] w_ps;

    assign w_gs       = w_g[4*s +: 4];
    assign w_ps       = w_p[4*s +: 4];
    assign w_c[s + 1] = slice_ggen(w_gs, w_ps) | ((&w_ps) & w_c[s]);

    for (genvar k = 0; k < 4; k++) begin : g_bit
      if (4 * s + k < DW) begin : g_out
        assign o_diff[4*s + k] = w_ps[k] ^ slice_carry(w_gs, w_ps, w_c[s], k);
      end
    end
  end

  assign o_no_borrow = w_c[NS];

endmodule

// File: rtl/seq_divider_32.sv
// seq_divider_32
// Iterative unsigned restoring divider producing one quotient bit per clock.
// Ports:
//   CLK, RESET    : clock, asynchronous active-high reset
//   start         : request, sampled only while busy=0
//   dividend      : numerator, sampled with start
//   divisor       : denominator, sampled with start
//   busy          : high while a division is iterating
//   done          : one-cycle completion pulse
//   quotient      : registered result, held until the next completion
//   remainder     : registered result, held until the next completion
//   div_by_zero   : registered flag, valid with done, held likewise
//   o_dbg_state   : current FSM state (state_t encoding)
//
// Handshake: an operation is accepted on any rising edge where busy=0 and
// start=1; dividend/divisor are captured on that edge only. start while
// busy=1 is ignored. Completion is signalled by done=1 for exactly one cycle,
// with busy already low, so a start presented in the done cycle is accepted
// on the next edge. A nonzero divisor completes WIDTH edges after
// acceptance; a zero divisor completes one edge after acceptance without
// ever raising busy.
module seq_divider_32
  import seq_divider_32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             o_dbg_state
);

  localparam int               LP_CNT_W = cnt_bits(WIDTH);
  localparam logic [WIDTH-1:0] LP_DBZ_Q = '1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_finish;

  // The partial remainder is always below the divisor between iterations,
  // so WIDTH bits hold it; the extra bit only exists in the shifted value.
  logic [WIDTH-1:0]      r_rem;
  logic [WIDTH-1:0]      r_q;
  logic [WIDTH-1:0]      r_dvs;
  logic [LP_CNT_W-1:0]   r_cnt;
  logic                  r_zero_pend;

  logic                  r_done;
  logic [WIDTH-1:0]      r_quotient;
  logic [WIDTH-1:0]      r_remainder;
  logic                  r_dbz;

  logic [WIDTH:0]        w_shifted;
  logic [WIDTH-1:0]      w_diff;
  logic                  w_no_borrow;
  logic [WIDTH-1:0]      w_rem_nxt;
  logic [WIDTH-1:0]      w_q_nxt;

  assign w_shifted = {r_rem, r_q[WIDTH-1]};

  cla_subtractor #(
    .W  (WIDTH + 1),
    .DW (WIDTH)
  ) u_sub (
    .i_a         (w_shifted),
    .i_b         ({1'b0, r_dvs}),
    .o_diff      (w_diff),
    .o_no_borrow (w_no_borrow)
  );

  // Restore by keeping the shifted value when the trial subtraction borrows.
  assign w_rem_nxt = w_no_borrow ? w_diff : w_shifted[WIDTH-1:0];
  assign w_q_nxt   = {r_q[WIDTH-2:0], w_no_borrow};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (divisor != '0) begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (r_cnt == LP_CNT_W'(1)) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rem       <= '0;
      r_q         <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_zero_pend <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_zero_pend <= 1'b0;

      if (w_accept) begin
        r_q         <= dividend;
        r_dvs       <= divisor;
        r_rem       <= '0;
        r_cnt       <= LP_CNT_W'(WIDTH);
        r_zero_pend <= (divisor == '0);
      end else if (r_state == RUN) begin
        r_q   <= w_q_nxt;
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt - LP_CNT_W'(1);
      end

      // The zero path reports one edge after acceptance; r_q still holds
      // the captured dividend even if a new request is accepted this edge.
      if (w_finish) begin
        r_quotient  <= w_q_nxt;
        r_remainder <= w_rem_nxt;
        r_dbz       <= 1'b0;
        r_done      <= 1'b1;
      end else if (r_zero_pend) begin
        r_quotient  <= LP_DBZ_Q;
        r_remainder <= r_q;
        r_dbz       <= 1'b1;
        r_done      <= 1'b1;
      end
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_divider_32.sv
// tb_seq_divider_32
// Directed bench for seq_divider_32: reset values, normal divisions,
// extremes, divide-by-zero, ignored start while busy, asynchronous reset
// mid-run and back-to-back operation. Expected results are hand-computed
// and queued on issue; they are popped and compared at each done.
module tb_seq_divider_32;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // {div_by_zero, quotient, remainder}
  logic [64:0] exp_q[$];

  seq_divider_32 dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one request for one edge; returns 1 time unit after E0.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input bit track);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (track) exp_q.push_back({edbz, eq, er});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    if (done !== 1'b1) check({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_result(input string tag);
    logic [64:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_quot"}, quotient, e[63:32]);
    check({tag, "_rem"},  remainder, e[31:0]);
    check({tag, "_dbz"},  32'(div_by_zero), 32'(e[64]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;

    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem",  remainder, 32'd0);
    check("rst_dbz",  32'(div_by_zero), 32'd0);
    RESET = 1'b0;
    tick();

    // 100 / 7 = 14 r 2
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    check("t1_busy_e0", 32'(busy), 32'd1);
    wait_done("t1", 40, cyc);
    check("t1_latency", 32'(cyc), 32'd32);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    check_result("t1");
    tick();
    check("t1_done_fall", 32'(done), 32'd0);
    check("t1_hold_quot", quotient, 32'd14);

    // Extremes
    issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    wait_done("t2a", 40, cyc);
    check_result("t2a");
    tick();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
    wait_done("t2b", 40, cyc);
    check_result("t2b");
    tick();

    // Divide by zero: 5 / 0
    issue(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);
    check("t3_busy_e0", 32'(busy), 32'd0);
    check("t3_done_e0", 32'(done), 32'd0);
    tick();
    check_result("t3");
    check("t3_busy_e1", 32'(busy), 32'd0);
    tick();
    check("t3_done_fall", 32'(done), 32'd0);
    check("t3_dbz_hold", 32'(div_by_zero), 32'd1);
    check("t3_busy_after", 32'(busy), 32'd0);

    // 3 / 10 = 0 r 3, with an ignored start mid-run
    issue(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1'b1);
    repeat (5) tick();
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4", 40, cyc);
    check("t4_latency", 32'(cyc + 6), 32'd32);
    check_result("t4");
    tick();

    // Asynchronous reset 10 cycles into 1000 / 3
    issue(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) tick();
    check("t5_busy_before_rst", 32'(busy), 32'd1);
    RESET = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_quot", quotient, 32'd0);
    check("t5_rst_rem",  remainder, 32'd0);
    check("t5_rst_dbz",  32'(div_by_zero), 32'd0);
    tick();
    RESET = 1'b0;
    tick();
    issue(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b1);
    wait_done("t5", 40, cyc);
    check("t5_latency", 32'(cyc), 32'd32);
    check_result("t5");
    tick();

    // Back-to-back with start held high: 81/9 then 17/4
    dividend = 32'd81;
    divisor  = 32'd9;
    start    = 1'b1;
    exp_q.push_back({1'b0, 32'd9, 32'd0});
    tick();
    check("t6a_busy_e0", 32'(busy), 32'd1);
    wait_done("t6a", 40, cyc);
    check("t6a_latency", 32'(cyc), 32'd32);
    check_result("t6a");
    dividend = 32'd17;
    divisor  = 32'd4;
    exp_q.push_back({1'b0, 32'd4, 32'd1});
    tick();
    start = 1'b0;
    check("t6b_busy_e0", 32'(busy), 32'd1);
    check("t6b_hold_quot", quotient, 32'd9);
    wait_done("t6b", 40, cyc);
    check("t6b_latency", 32'(cyc), 32'd32);
    check_result("t6b");
    tick();
    check("t6b_done_fall", 32'(done), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
